// File: rtl/sb_arbiter.sv
// sb_arbiter: two-master data-memory arbiter with sub-word loads and read-modify-write stores.
module sb_arbiter #(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_un_sign,
    input  logic [1:0]        m0_byte_mask,
    input  logic              m0_re,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_ack,
    input  logic              m1_un_sign,
    input  logic [1:0]        m1_byte_mask,
    input  logic              m1_re,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_ack,
    input  logic [31:0]       s_rdata,
    output logic              s_rw_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [31:0]       s_wdata_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;
    state_t state, state_n;
    logic              last, id, we, un;
    logic [1:0]        mk;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              req0, req1, gnt1, g_we, g_sub, ack, load_ack;
    logic [1:0]        g_mk;
    logic [4:0]        sh_b, sh_l;
    logic [31:0]       shifted, lane_m, merged, ext;
    logic [15:0]       half;
    always_comb begin
        req0    = m0_re | m0_we;
        req1    = m1_re | m1_we;
        gnt1    = req1 & (~req0 | (RR_EN & ~last));
        g_we    = gnt1 ? m1_we : m0_we;
        g_mk    = gnt1 ? m1_byte_mask : m0_byte_mask;
        g_sub   = (g_mk == 2'b01) | (g_mk == 2'b10);
        sh_b    = {addr[1:0], 3'b000};
        sh_l    = (mk == 2'b01) ? sh_b : {addr[1], 4'b0000};
        shifted = s_rdata >> sh_b;
        half    = addr[1] ? s_rdata[31:16] : s_rdata[15:0];
        ext     = (mk == 2'b01) ? {{24{shifted[7] & ~un}}, shifted[7:0]} :
                  (mk == 2'b10) ? {{16{half[15] & ~un}}, half} : s_rdata;
        // the merged word reuses the wdata register, so WR always drives wdata
        lane_m  = ((mk == 2'b01) ? 32'h0000_00FF : 32'h0000_FFFF) << sh_l;
        merged  = (s_rdata & ~lane_m) | ((wdata << sh_l) & lane_m);
    end
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = (req0 | req1) ? ((g_we & ~g_sub) ? WR : RD) : IDLE;
            RD:   state_n = RDW;
            RDW:  state_n = we ? WR : IDLE;
            WR:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            id    <= 1'b0;
            we    <= 1'b0;
            un    <= 1'b0;
            mk    <= 2'b00;
            addr  <= '0;
            wdata <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && (req0 | req1)) begin
                id    <= gnt1;
                last  <= gnt1;
                we    <= g_we;
                un    <= gnt1 ? m1_un_sign : m0_un_sign;
                mk    <= g_mk;
                addr  <= gnt1 ? m1_addr : m0_addr;
                wdata <= gnt1 ? m1_wdata : m0_wdata;
            end
            if (state == RDW && we)
                wdata <= merged;
        end
    end
    // reset aborts at once: no ack and no write even in the cycle reset is seen
    always_comb begin
        ack       = ~rst & ((state == RDW & ~we) | (state == WR));
        load_ack  = ~rst & (state == RDW) & ~we;
        m0_ack    = ack & ~id;
        m1_ack    = ack & id;
        m0_rdata  = (load_ack & ~id) ? ext : 32'h0;
        m1_rdata  = (load_ack & id) ? ext : 32'h0;
        s_rw_o    = ~rst & (state == WR);
        s_addr_o  = (state != IDLE) ? {addr[ADDR_W-1:2], 2'b00} : '0;
        s_wdata_o = (state == WR) ? wdata : 32'h0;
        busy_o    = state != IDLE;
    end
endmodule

// File: doc/sb_arbiter.md
Name: sb_arbiter

Overview:
- Arbitrates two bus masters (m0 = core load/store unit, m1 = future DMA/debug port) onto the single data-memory slave port.
- Performs sub-word access handling itself:
  - lane extraction with sign/zero extension on loads;
  - read-modify-write on byte/halfword stores, because the slave only accepts full-word writes.
- Sits between the core's external load/store outputs and dmem, replacing the pass-through bus path.

Parameters:
- ADDR_W, 32, master/slave address width; data width is fixed at 32.
- RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority, m0 always wins.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_un_sign  in  1  1 = zero-extend load, 0 = sign-extend
- m0_byte_mask  in  2  00 = word, 01 = byte, 10 = halfword, 11 = word
- m0_re  in  1  read request
- m0_we  in  1  write request; takes precedence over m0_re if both are high
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  store data, right-aligned
- m0_rdata  out  32  load data, valid only while m0_ack=1, else 0
- m0_ack  out  1  one-cycle completion pulse
- m1_*  same set as m0_*, for master 1
- s_rdata  in  32  slave read data; registered, valid one cycle after address
- s_rw_o  out  1  1 = write
- s_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- s_wdata_o  out  32  full-word write data
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: state = IDLE, last_grant = m1 (so m0 wins the first tie); all outputs 0; latched request cleared.
- Reset asserted mid-transaction:
  - abort immediately; no ack is issued;
  - s_rw_o = 0 on the following cycle;
  - a pending RMW write never occurs.
- Request = (mX_re | mX_we). A master holds all request fields stable until it sees ack, then drops the request or presents a new one on the next cycle.
- IDLE, arbitration:
  - only one requester: grant it;
  - both requesting and RR_EN = 1: grant the master that is not last_grant;
  - both requesting and RR_EN = 0: grant m0.
- On grant:
  - latch winner id, we, un_sign, byte_mask, addr, wdata;
  - update last_grant;
  - next state: WR if it is a word store, otherwise RD.
- RD: s_addr_o = latched word address, s_rw_o = 0. Next state RDW.
- RDW: s_rdata is valid.
  - Load: pulse the winner's ack; rdata = extracted lane; next state IDLE.
  - Sub-word store: merged word = s_rdata with the selected lane replaced by wdata[7:0] or wdata[15:0]; latch it; next state WR.
- WR:
  - s_rw_o = 1; s_addr_o = word address; s_wdata_o = wdata (word) or the merged word;
  - pulse the winner's ack; next state IDLE;
  - the memory write commits at the edge ending WR.
- Lane select (little-endian):
  - byte: lane = addr[1:0];
  - halfword: addr[1] selects the half, addr[0] is ignored;
  - word: addr[1:0] ignored.
- Load extension: byte and halfword loads are zero-extended if un_sign = 1, otherwise sign-extended from bit 7 or bit 15.
- Latency, counted from the cycle a request is first sampled in IDLE to the ack cycle:
  - word store 1;
  - load 2;
  - sub-word store 3.
- Maximum throughput is one transaction per (latency + 1) cycles, because the arbiter returns to IDLE between transactions.
- The non-granted master waits with ack = 0. Its request is re-arbitrated in the next IDLE; no request is dropped.
- Outside RD/RDW/WR: s_rw_o = 0, s_addr_o = 0, s_wdata_o = 0.
- The ack of the non-winning master is never asserted. At most one ack is high in any cycle.

Test Plan:
- Word read:
  - preload mem[0x10] = 0xDEADBEEF; m0_re = 1, addr = 0x10, mask = 00;
  - expect m0_ack 2 cycles later with m0_rdata = 0xDEADBEEF, s_rw_o = 0 throughout.
- Sign/zero byte load:
  - mem[0x20] = 0x0080FF7F; m0 byte load at addr 0x21 with un_sign = 0;
  - expect m0_rdata = 0xFFFFFFFF; same load with un_sign = 1 gives 0x000000FF;
  - halfword load at 0x22 with un_sign = 0 gives 0x00000080.
- Byte store RMW:
  - mem[0x30] = 0x11223344; m1_we, mask = 01, addr = 0x32, wdata = 0xAB;
  - expect sequence RD → RDW → WR with s_wdata_o = 0x11AB3344;
  - m1_ack in the 3rd cycle; a readback returns 0x11AB3344.
- Round robin:
  - m0 and m1 both hold word loads from reset;
  - expect acks in order m0, m1, m0, m1, each 3 cycles apart;
  - with RR_EN = 0, every ack goes to m0 while m0 keeps requesting.
- Word store latency:
  - m0_we, mask = 00, addr = 0x40, wdata = 0x12345678;
  - expect s_rw_o = 1 and m0_ack in the cycle after the request is sampled; mem[0x40] updated at the next edge.
- Reset mid-RMW:
  - assert rst during RDW of a halfword store;
  - expect no ack, s_rw_o never 1, memory unchanged, busy_o = 0 the cycle after reset.
